// File: rtl/flappy_pkg.sv
// Shared types for the Flappy Bird game sequencer: game states and BCD score.
// No logic beyond the saturating BCD score increment.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } score_t;

  localparam logic [7:0] SCORE_MAX = 8'h99;

  // Two-digit BCD increment that sticks at 99.
  function automatic score_t score_inc(input score_t s);
    score_t r;
    r = s;
    if (s == score_t'(SCORE_MAX)) begin
      r = s;
    end else if (s.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = s.tens + 4'd1;
    end else begin
      r.ones = s.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Free-running divider: one-cycle registered tick every TICK_DIV clk cycles.
// Latency: tick is high the cycle after the counter reads TICK_DIV-1; no backpressure.
module game_tick_gen #(
  parameter int TICK_DIV = 4_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == TICK_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: IDLE/PLAY/DYING/OVER flow, flap/bird/pipe strobes, BCD score.
// Strobes are zero-latency with tick; no backpressure. Optional pause via FLAPPY_PAUSE_EN.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int TICK_DIV    = 4_000_000,
  parameter int PIPE_DIV    = 4,
  parameter int DEATH_TICKS = 8
) (
`ifdef FLAPPY_PAUSE_EN
  input  logic       pause_btn,
`endif
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flap_btn,
  input  logic       collision,
  input  logic       pipe_passed,
  output logic       tick,
  output logic       bird_step,
  output logic       flap_cmd,
  output logic       pipe_step,
  output logic       clear_field,
  output logic [7:0] score,
  output logic [1:0] state,
  output logic       game_over
);

  localparam int PCW = (PIPE_DIV > 1) ? $clog2(PIPE_DIV) : 1;
  localparam int DCW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  localparam logic [PCW-1:0] PIPE_LAST  = PCW'(PIPE_DIV - 1);
  localparam logic [DCW-1:0] DEATH_LAST = DCW'(DEATH_TICKS - 1);

  game_state_e    state_q, state_d;
  logic           flap_prev_q;
  logic           flap_pending_q, flap_pending_d;
  logic [PCW-1:0] pipe_cnt_q, pipe_cnt_d;
  logic [DCW-1:0] death_cnt_q, death_cnt_d;
  score_t         score_q, score_d;
  logic           flap_rise;
  logic           paused;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign flap_rise = flap_btn & ~flap_prev_q;

`ifdef FLAPPY_PAUSE_EN
  logic pause_prev_q, paused_q, paused_d;

  always_comb begin
    paused_d = paused_q;
    if (state_q != PLAY) paused_d = 1'b0;
    else if (pause_btn & ~pause_prev_q) paused_d = ~paused_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_prev_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      pause_prev_q <= pause_btn;
      paused_q     <= paused_d;
    end
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    flap_pending_d = flap_pending_q;
    pipe_cnt_d     = pipe_cnt_q;
    death_cnt_d    = death_cnt_q;
    score_d        = score_q;
    bird_step      = 1'b0;
    flap_cmd       = 1'b0;
    pipe_step      = 1'b0;
    case (state_q)
      IDLE: begin
        pipe_cnt_d  = '0;
        death_cnt_d = '0;
        score_d     = '0;
        if (flap_rise) begin
          state_d        = PLAY;
          flap_pending_d = 1'b1;
        end
      end
      PLAY: begin
        if (!paused) begin
          // Collision outranks the tick and any coincident score pulse.
          if (collision) begin
            state_d        = DYING;
            flap_pending_d = 1'b0;
          end else begin
            if (tick) begin
              bird_step      = 1'b1;
              flap_cmd       = flap_pending_q;
              pipe_step      = (pipe_cnt_q == PIPE_LAST);
              pipe_cnt_d     = (pipe_cnt_q == PIPE_LAST) ? '0 : pipe_cnt_q + 1'b1;
              flap_pending_d = 1'b0;
            end
            if (flap_rise)   flap_pending_d = 1'b1;
            if (pipe_passed) score_d = score_inc(score_q);
          end
        end
      end
      DYING: begin
        if (tick) begin
          bird_step = 1'b1;
          if (death_cnt_q == DEATH_LAST) begin
            state_d     = OVER;
            death_cnt_d = '0;
          end else begin
            death_cnt_d = death_cnt_q + 1'b1;
          end
        end
      end
      OVER: begin
        if (flap_rise) begin
          state_d = IDLE;
          score_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      flap_prev_q    <= 1'b0;
      flap_pending_q <= 1'b0;
      pipe_cnt_q     <= '0;
      death_cnt_q    <= '0;
      score_q        <= '0;
    end else begin
      state_q        <= state_d;
      flap_prev_q    <= flap_btn;
      flap_pending_q <= flap_pending_d;
      pipe_cnt_q     <= pipe_cnt_d;
      death_cnt_q    <= death_cnt_d;
      score_q        <= score_d;
    end
  end

  assign clear_field = (state_q == IDLE);
  assign game_over   = (state_q == OVER);
  assign state       = state_q;
  assign score       = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Randomized bench for flappy_game_ctrl with a cycle-level reference model and
// an expected-value queue drained by an independent monitor on the falling edge.
module tb_flappy_game_ctrl;

  localparam int TD = 4;
  localparam int PD = 2;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flap_btn = 1'b0;
  logic       collision = 1'b0;
  logic       pipe_passed = 1'b0;
  logic       tick, bird_step, flap_cmd, pipe_step, clear_field, game_over;
  logic [7:0] score;
  logic [1:0] state;

  always #5 clk = ~clk;

`ifdef FLAPPY_PAUSE_EN
  logic pause_btn = 1'b0;
`endif

  flappy_game_ctrl #(.TICK_DIV(TD), .PIPE_DIV(PD), .DEATH_TICKS(DT)) dut (
`ifdef FLAPPY_PAUSE_EN
    .pause_btn  (pause_btn),
`endif
    .clk        (clk),
    .reset_n    (reset_n),
    .flap_btn   (flap_btn),
    .collision  (collision),
    .pipe_passed(pipe_passed),
    .tick       (tick),
    .bird_step  (bird_step),
    .flap_cmd   (flap_cmd),
    .pipe_step  (pipe_step),
    .clear_field(clear_field),
    .score      (score),
    .state      (state),
    .game_over  (game_over)
  );

  typedef struct packed {
    logic       tick;
    logic       bird;
    logic       flap;
    logic       pipe;
    logic       clr;
    logic       go;
    logic [1:0] st;
    logic [7:0] score;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: game mode, pending flap, tick/pipe/death counts, decimal score.
  int m_mode = 0;
  bit m_pend = 0;
  int m_pcnt = 0;
  int m_dcnt = 0;
  int m_score = 0;
  int m_n = 0;
  bit m_prev = 0;

  function automatic logic [7:0] to_bcd(input int s);
    logic [3:0] t, o;
    t = 4'(s / 10);
    o = 4'(s % 10);
    return {t, o};
  endfunction

  function automatic bit tick_due();
    return (m_n >= TD) && (m_n % TD == 0);
  endfunction

  task automatic step(input bit rst, input bit btn, input bit col, input bit pp);
    obs_t e;
    bit   t, rise;
    reset_n     = !rst;
    flap_btn    = btn;
    collision   = col;
    pipe_passed = pp;
    e = '0;
    if (rst) begin
      m_mode = 0; m_pend = 0; m_pcnt = 0; m_dcnt = 0; m_score = 0; m_n = 0; m_prev = 0;
      e.clr = 1'b1;
    end else begin
      t       = tick_due();
      rise    = btn && !m_prev;
      e.tick  = t;
      e.clr   = (m_mode == 0);
      e.go    = (m_mode == 3);
      e.st    = 2'(m_mode);
      e.score = to_bcd(m_score);
      case (m_mode)
        0: begin
          m_pcnt = 0; m_dcnt = 0; m_score = 0;
          if (rise) begin m_mode = 1; m_pend = 1; end
        end
        1: begin
          if (col) begin
            m_mode = 2; m_pend = 0;
          end else begin
            if (t) begin
              e.bird = 1'b1;
              e.flap = m_pend;
              e.pipe = (m_pcnt == PD - 1);
              m_pcnt = (m_pcnt + 1) % PD;
              m_pend = 0;
            end
            if (rise) m_pend = 1;
            if (pp && m_score < 99) m_score++;
          end
        end
        2: begin
          if (t) begin
            e.bird = 1'b1;
            m_dcnt++;
            if (m_dcnt == DT) begin m_mode = 3; m_dcnt = 0; end
          end
        end
        3: begin
          if (rise) begin m_mode = 0; m_score = 0; end
        end
        default: ;
      endcase
      m_prev = btn;
      m_n++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {tick, bird_step, flap_cmd, pipe_step, clear_field, game_over, state, score};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: got tick=%b bird=%b flap=%b pipe=%b clr=%b go=%b st=%0d score=%h, want tick=%b bird=%b flap=%b pipe=%b clr=%b go=%b st=%0d score=%h",
                 vectors, $time, a.tick, a.bird, a.flap, a.pipe, a.clr, a.go, a.st, a.score,
                 e.tick, e.bird, e.flap, e.pipe, e.clr, e.go, e.st, e.score);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    repeat (3) step(1, 0, 0, 0);
    // Idle with no button: ticks only, field held clear.
    repeat (20) step(0, 0, 0, 0);
    // Start the game; button held a random number of cycles.
    step(0, 1, 0, 0);
    repeat ($urandom_range(0, 2)) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, ($urandom % 5) == 0, 0, 0);
    // Score 101 pipes: BCD carry and saturation at 99.
    for (int i = 0; i < 101; i++) begin
      step(0, ($urandom % 6) == 0, 0, 1);
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0);
    end
    // Collision coincident with tick and pipe_passed.
    for (int i = 0; i < TD && !tick_due(); i++) step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    // Dying: flaps, collisions and pipe pulses ignored.
    for (int i = 0; i < 20; i++)
      step(0, (m_mode == 2) && (($urandom % 2) == 0), ($urandom % 2) == 0, ($urandom % 2) == 0);
    // Over -> Idle -> Play.
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    // Leave a flap pending, then reset mid-play.
    if (tick_due()) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);
    // Random soak with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 150) == 0) step(1, 0, 0, 0);
      else step(0, ($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 8) == 0);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Game sequencer for the Flappy Bird design; sits between the board top-level and the bird/pipe datapath.
- Replaces clock-divider-driven FSM clocking with single-clock enables.
- Runs the IDLE/PLAY/DYING/OVER game flow, converts the flap button into flap commands, strobes bird and pipe updates, and keeps the 2-digit BCD score.

Parameters:
- TICK_DIV, 4_000_000: clk cycles per game tick (12.5 Hz at 50 MHz); must be >= 2.
- PIPE_DIV, 4: game ticks per pipe shift; must be >= 1.
- DEATH_TICKS, 8: ticks spent in DYING before OVER; must be >= 1.

Ports:
- clk  in  1: system clock (CLOCK_50 domain).
- reset_n  in  1: asynchronous, active-low reset.
- flap_btn  in  1: flap button, already synchronized, active-high level.
- collision  in  1: level from datapath; bird hit pipe or ground.
- pipe_passed  in  1: one-cycle pulse from datapath when the bird clears a pipe.
- tick  out  1: one-cycle game-tick pulse.
- bird_step  out  1: advance bird physics one step.
- flap_cmd  out  1: apply upward impulse; only ever asserted together with bird_step.
- pipe_step  out  1: shift pipes one column.
- clear_field  out  1: datapath holds bird and pipes at start positions.
- score  out  8: {tens, ones} BCD.
- state  out  2: IDLE=0, PLAY=1, DYING=2, OVER=3.
- game_over  out  1: high in OVER.

Behaviour:
- Reset (async on reset_n low):
  - state=IDLE; all counters, score, flap_pending and flap_prev cleared.
  - tick, bird_step, flap_cmd and pipe_step are 0; clear_field=1; game_over=0.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps; it runs in every state.
  - tick is a registered pulse, high for the one cycle after the counter reads TICK_DIV-1.
- Flap edge detect:
  - flap_rise = flap_btn & ~flap_prev, where flap_prev is registered.
  - In PLAY, flap_rise sets flap_pending, which holds until consumed.
  - Multiple rises between ticks collapse into one flap.
- Strobe timing: bird_step, flap_cmd and pipe_step are combinational from registered state, tick and flap_pending, so they are coincident with tick (zero latency).
- IDLE:
  - clear_field=1; score held at 0; no strobes.
  - flap_rise -> PLAY on the next cycle, and it also sets flap_pending, so the first PLAY tick flaps.
  - pipe tick counter and death counter reset to 0.
- PLAY:
  - Each tick: bird_step=1 and flap_cmd=flap_pending; flap_pending clears that cycle.
  - A flap_rise in the same cycle as a tick is not lost: it sets pending for the next tick.
  - Pipe tick counter counts ticks 0..PIPE_DIV-1; pipe_step=1 on the tick where it reads PIPE_DIV-1, then it wraps.
  - pipe_passed increments score as BCD (ones 9 -> 0 with tens carry) and saturates at 99.
  - collision -> DYING next cycle. Collision has top priority:
    - a tick coincident with collision asserts no bird_step, flap_cmd or pipe_step;
    - a coincident pipe_passed does not score.
  - flap_pending clears on exit from PLAY.
- DYING:
  - On each tick: bird_step=1 (bird falls); flap_cmd=0; pipe_step=0.
  - Flaps, collision and pipe_passed are ignored.
  - Death counter counts ticks; on the DEATH_TICKS-th tick -> OVER.
- OVER: game_over=1; score held; no strobes; flap_rise -> IDLE, which clears score and field.
- Counter widths: from $clog2 of each parameter; no overflow is possible because all counters wrap or stop at bound.
- Mid-operation reset: any state returns to reset values immediately; no pending flap survives.

Optional Feature:
- Macro FLAPPY_PAUSE_EN.
- When defined:
  - adds input port pause_btn (1 bit, synchronized, active-high);
  - its rising edge toggles a paused flag, only in PLAY;
  - while paused: no strobes; pipe counter frozen; flap_rise, collision and pipe_passed ignored; tick still pulses;
  - paused clears on leaving PLAY or on reset.
- When undefined: no port, no paused logic, and behaviour is exactly as above.

Decomposition:
- Package flappy_pkg: typedef enum logic [1:0] game_state_e {IDLE, PLAY, DYING, OVER}; BCD digit typedef; constant SCORE_MAX = 8'h99.
- One sub-module: game_tick_gen (parameter TICK_DIV; ports clk, reset_n, tick). It is reused by the pipe/animation blocks.

Test Plan (TICK_DIV=4, PIPE_DIV=2, DEATH_TICKS=3):
- Release reset, hold flap_btn=0 for 20 cycles -> state=0, clear_field=1, tick pulses every 4 cycles, no strobes.
- Pulse flap_btn in IDLE -> state=1 next cycle; first tick has bird_step=1 and flap_cmd=1; pipe_step on every 2nd tick; subsequent ticks flap_cmd=0 unless flapped.
- In PLAY, pulse pipe_passed 101 times -> score goes 0x09 -> 0x10, then saturates at 0x99.
- Assert collision in the same cycle as tick and pipe_passed -> no strobes and no score change that cycle; state=2 next cycle; 3 ticks with bird_step=1 and flap_cmd=0; then state=3 and game_over=1.
- In OVER, flap_btn rise -> state=0, score=0x00, clear_field=1; a second rise -> PLAY.
- Drop reset_n mid-PLAY with flap_pending set -> all outputs at reset values asynchronously; after release, the first tick gives no strobes.
